// File: rtl/ex_mc_pkg.sv
// Shared encodings for the execute stage: ALU function codes, FSM states and the
// control bundle that travels with each operation to the MEM stage.
package ex_mc_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_MUL = 4'd8
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] load_mode;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_mc_mul.sv
// Radix-2 shift-add multiplier: XLEN iterations after start, keeps the low XLEN
// product bits. done_o is high during the final iteration.
module ex_mc_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, mcand_q, mplier_q;

    assign busy_o    = (cnt_q != '0);
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n || kill_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            cnt_q    <= CW'(XLEN);
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_o) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/ex_mc_stage.sv
// Execute stage with a registered valid/ready output slot toward MEM. Defining
// EX_MC_MUL_EN adds the iterative multiply path (IDLE/MUL/DONE FSM).
module ex_mc_stage
    import ex_mc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              in_reg_dst,
    input  logic              in_reg_write,
    input  logic              in_alu_src,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic              in_mem_to_reg,
    input  logic [1:0]        in_load_mode,
    input  logic [3:0]        in_alu_ctrl,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_rs_val,
    input  logic [XLEN-1:0]   in_rt_val,
    input  logic [XLEN-1:0]   in_pc_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_zero,
    output logic              out_reg_write,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic              out_mem_to_reg,
    output logic [1:0]        out_load_mode,
    output logic [REG_AW-1:0] out_wb_dest,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_rt_val,
    output logic [XLEN-1:0]   out_branch_target
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]   op_b, alu_res, br_tgt;
    logic [SHW-1:0]    shamt;
    logic [REG_AW-1:0] wb_dest;
    ex_ctrl_t          ctrl_in;
    logic              slot_free, take, load_new, load_mul;
    logic [XLEN-1:0]   ld_res, ld_rt, ld_br;
    logic [REG_AW-1:0] ld_wb;
    ex_ctrl_t          ld_ctrl;

    logic              out_valid_q, zero_q;
    logic [XLEN-1:0]   res_q, rt_q, br_q;
    logic [REG_AW-1:0] wb_q;
    ex_ctrl_t          ctrl_q;

    assign op_b      = in_alu_src ? in_imm : in_rt_val;
    assign shamt     = in_imm[6+SHW-1:6];
    assign wb_dest   = in_reg_dst ? in_rd : in_rt;
    assign br_tgt    = in_pc_next + (in_imm << 2);
    assign ctrl_in   = '{reg_write: in_reg_write, mem_write: in_mem_write, mem_read: in_mem_read,
                         mem_to_reg: in_mem_to_reg, load_mode: in_load_mode};
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        alu_res = '0;
        case (in_alu_ctrl)
            ALU_ADD: alu_res = in_rs_val + op_b;
            ALU_SUB: alu_res = in_rs_val - op_b;
            ALU_AND: alu_res = in_rs_val & op_b;
            ALU_OR:  alu_res = in_rs_val | op_b;
            ALU_NOR: alu_res = ~(in_rs_val | op_b);
            ALU_SLT: alu_res = XLEN'($signed(in_rs_val) < $signed(op_b));
            ALU_SLL: alu_res = op_b << shamt;
            ALU_SRL: alu_res = op_b >> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MC_MUL_EN
    ex_state_e         state_q, state_d;
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [XLEN-1:0]   mul_prod, pend_rt_q, pend_br_q;
    logic [REG_AW-1:0] pend_wb_q;
    ex_ctrl_t          pend_ctrl_q;

    assign is_mul    = (in_alu_ctrl == ALU_MUL);
    assign in_ready  = rst_n && (state_q == ST_IDLE) && slot_free;
    assign take      = in_valid && in_ready && !flush;
    assign mul_start = take && is_mul;

    ex_mc_mul #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .kill_i    (flush),
        .a_i       (in_rs_val),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        load_new = 1'b0;
        load_mul = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take && !is_mul) load_new = 1'b1;
                if (mul_start) state_d = ST_MUL;
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_DONE;
                else if (!mul_busy) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (slot_free) begin
                    load_mul = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            load_mul = 1'b0;
        end
    end

    // The multiply's side-band fields are parked here so later inputs cannot leak into it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_ctrl_q <= '0;
            pend_wb_q   <= '0;
            pend_rt_q   <= '0;
            pend_br_q   <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                pend_ctrl_q <= ctrl_in;
                pend_wb_q   <= wb_dest;
                pend_rt_q   <= in_rt_val;
                pend_br_q   <= br_tgt;
            end
        end
    end

    assign ld_res  = load_mul ? mul_prod    : alu_res;
    assign ld_ctrl = load_mul ? pend_ctrl_q : ctrl_in;
    assign ld_wb   = load_mul ? pend_wb_q   : wb_dest;
    assign ld_rt   = load_mul ? pend_rt_q   : in_rt_val;
    assign ld_br   = load_mul ? pend_br_q   : br_tgt;
`else
    assign in_ready = rst_n && slot_free;
    assign take     = in_valid && in_ready && !flush;
    assign load_new = take;
    assign load_mul = 1'b0;
    assign ld_res   = alu_res;
    assign ld_ctrl  = ctrl_in;
    assign ld_wb    = wb_dest;
    assign ld_rt    = in_rt_val;
    assign ld_br    = br_tgt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            res_q       <= '0;
            rt_q        <= '0;
            br_q        <= '0;
            wb_q        <= '0;
            ctrl_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_new || load_mul) begin
            out_valid_q <= 1'b1;
            zero_q      <= (ld_res == '0);
            res_q       <= ld_res;
            rt_q        <= ld_rt;
            br_q        <= ld_br;
            wb_q        <= ld_wb;
            ctrl_q      <= ld_ctrl;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_zero          = zero_q;
    assign out_alu_result    = res_q;
    assign out_rt_val        = rt_q;
    assign out_branch_target = br_q;
    assign out_wb_dest       = wb_q;
    assign out_reg_write     = ctrl_q.reg_write;
    assign out_mem_write     = ctrl_q.mem_write;
    assign out_mem_read      = ctrl_q.mem_read;
    assign out_mem_to_reg    = ctrl_q.mem_to_reg;
    assign out_load_mode     = ctrl_q.load_mode;

endmodule

// File: tb/tb_ex_mc_stage.sv
// Bench for ex_mc_stage: vector table, handwritten stall/flush/reset/multiply
// sequences, and a random phase scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_ex_mc_stage;
    import ex_mc_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_ready, flush;
    logic              in_reg_dst, in_reg_write, in_alu_src, in_mem_write, in_mem_read, in_mem_to_reg;
    logic [1:0]        in_load_mode;
    logic [3:0]        in_alu_ctrl;
    logic [REG_AW-1:0] in_rd, in_rt;
    logic [XLEN-1:0]   in_imm, in_rs_val, in_rt_val, in_pc_next;
    logic              out_valid, out_ready, out_zero;
    logic              out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg;
    logic [1:0]        out_load_mode;
    logic [REG_AW-1:0] out_wb_dest;
    logic [XLEN-1:0]   out_alu_result, out_rt_val, out_branch_target;
    logic [5:0]        side_act;

    always #5 clk = ~clk;

    ex_mc_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_reg_dst(in_reg_dst), .in_reg_write(in_reg_write), .in_alu_src(in_alu_src),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_mem_to_reg(in_mem_to_reg),
        .in_load_mode(in_load_mode), .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd), .in_rt(in_rt),
        .in_imm(in_imm), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_pc_next(in_pc_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_load_mode(out_load_mode), .out_wb_dest(out_wb_dest),
        .out_alu_result(out_alu_result), .out_rt_val(out_rt_val), .out_branch_target(out_branch_target)
    );

    assign side_act = {out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg, out_load_mode};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic src, input logic rdst,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rta,
                         input logic [5:0] cb);
        in_alu_ctrl = op;  in_alu_src = src; in_reg_dst = rdst;
        in_rs_val   = rs;  in_rt_val  = rt;  in_imm     = imm;
        in_pc_next  = pc;  in_rd      = rd;  in_rt      = rta;
        {in_reg_write, in_mem_write, in_mem_read, in_mem_to_reg, in_load_mode} = cb;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(4'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Reference model: each accepted operation's expected MEM-stage record.
    typedef struct {
        logic [31:0] res, rt, br;
        logic [4:0]  wb;
        logic [5:0]  side;
    } exp_t;
    exp_t q[$];

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: return b << sh;
            ALU_SRL: return b >> sh;
`ifdef EX_MC_MUL_EN
            ALU_MUL: begin
                logic [63:0] p;
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model_now();
        exp_t e;
        logic [31:0] b;
        b      = in_alu_src ? in_imm : in_rt_val;
        e.res  = ref_alu(in_alu_ctrl, in_rs_val, b, (in_imm / 64) % 32);
        e.rt   = in_rt_val;
        e.br   = in_pc_next + in_imm * 32'd4;
        e.wb   = in_reg_dst ? in_rd : in_rt;
        e.side = {in_reg_write, in_mem_write, in_mem_read, in_mem_to_reg, in_load_mode};
        return e;
    endfunction

    logic [3:0] ops [10];

    task automatic rnd_cycle(input bit new_ops);
        exp_t e;
        if (new_ops) begin
            drive(ops[$urandom_range(0, 9)], 1'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom), 5'($urandom), 6'($urandom));
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("rnd_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rnd_res",  out_alu_result, e.res);
                chk("rnd_zero", 32'(out_zero), 32'(e.res == 0));
                chk("rnd_ctl",  32'({side_act, out_wb_dest}), 32'({e.side, e.wb}));
                chk("rnd_rt",   out_rt_val, e.rt);
                chk("rnd_br",   out_branch_target, e.br);
            end
        end
        if (in_valid && in_ready) q.push_back(model_now());
        step();
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        src, rdst;
        logic [31:0] rs, rt, imm, pc;
        logic [4:0]  rd, rta;
        logic [5:0]  cb;
        logic [31:0] e_res, e_br;
        logic        e_zero;
        logic [4:0]  e_wb;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, seen;
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL, 4'hF};

        //        op       src   rdst  rs            rt            imm           pc          rd  rta cb        res           br            z     wb
        tbl.push_back('{ALU_ADD, 1'b1, 1'b0, 32'd5,        32'd0,        32'd7,        32'h1000, 0, 9,  6'b100000, 32'd12,       32'h101C, 1'b0, 9});
        tbl.push_back('{ALU_SUB, 1'b0, 1'b1, 32'd9,        32'd9,        32'd0,        32'h1000, 3, 4,  6'b010001, 32'd0,        32'h1000, 1'b1, 3});
        tbl.push_back('{ALU_ADD, 1'b1, 1'b0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h100,  0, 2,  6'b001010, 32'hFFFFFFFF, 32'hFC,   1'b0, 2});
        tbl.push_back('{ALU_SLL, 1'b0, 1'b1, 32'd0,        32'd1,        32'h7C0,      32'h1000, 5, 0,  6'b000111, 32'h80000000, 32'h2F00, 1'b0, 5});
        tbl.push_back('{ALU_SRL, 1'b0, 1'b1, 32'd0,        32'h80000000, 32'h100,      32'h1000, 6, 0,  6'b100110, 32'h08000000, 32'h1400, 1'b0, 6});
        tbl.push_back('{ALU_SLT, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h1000, 7, 0,  6'b110000, 32'd1,        32'h1000, 1'b0, 7});
        tbl.push_back('{ALU_SLT, 1'b0, 1'b1, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h1000, 8, 0,  6'b011011, 32'd0,        32'h1000, 1'b1, 8});
        tbl.push_back('{ALU_AND, 1'b0, 1'b1, 32'hF0F0,     32'hFF00,     32'd0,        32'h1000, 10, 0, 6'b000001, 32'hF000,     32'h1000, 1'b0, 10});
        tbl.push_back('{ALU_OR,  1'b0, 1'b1, 32'hF0F0,     32'hFF00,     32'd0,        32'h1000, 11, 0, 6'b101010, 32'hFFF0,     32'h1000, 1'b0, 11});
        tbl.push_back('{ALU_NOR, 1'b0, 1'b1, 32'd0,        32'd0,        32'd0,        32'h1000, 12, 0, 6'b010101, 32'hFFFFFFFF, 32'h1000, 1'b0, 12});
        tbl.push_back('{4'hF,    1'b0, 1'b1, 32'd5,        32'd5,        32'd0,        32'h1000, 13, 0, 6'b111111, 32'd0,        32'h1000, 1'b1, 13});
        tbl.push_back('{ALU_ADD, 1'b1, 1'b0, 32'hFFFFFFF8, 32'd0,        32'd8,        32'h1000, 0, 14, 6'b100100, 32'd0,        32'h1020, 1'b1, 14});
        tbl.push_back('{ALU_SUB, 1'b0, 1'b1, 32'd3,        32'd5,        32'd0,        32'h1000, 15, 0, 6'b000010, 32'hFFFFFFFE, 32'h1000, 1'b0, 15});
`ifndef EX_MC_MUL_EN
        tbl.push_back('{ALU_MUL, 1'b0, 1'b1, 32'd6,        32'd7,        32'd0,        32'h1000, 16, 0, 6'b100001, 32'd0,        32'h1000, 1'b1, 16});
`endif

        // Reset: in_ready low while held, all outputs cleared.
        set_idle();
        rst_n = 1'b0;
        drive(ALU_ADD, 1'b1, 1'b0, 32'd5, 32'd1, 32'd7, 32'h40, 5'd1, 5'd2, 6'b111111);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_alu_result, 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_side_wb", 32'({side_act, out_wb_dest}), 32'd0);
        chk("rst_rt_br", out_rt_val | out_branch_target, 32'd0);
        rst_n = 1'b1;

        // Table: back-to-back ops, each visible one edge after accept.
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].src, tbl[i].rdst, tbl[i].rs, tbl[i].rt, tbl[i].imm,
                  tbl[i].pc, tbl[i].rd, tbl[i].rta, tbl[i].cb);
            in_valid = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_res", i), out_alu_result, tbl[i].e_res);
            chk($sformatf("tbl%0d_zero", i), 32'(out_zero), 32'(tbl[i].e_zero));
            chk($sformatf("tbl%0d_wb", i), 32'(out_wb_dest), 32'(tbl[i].e_wb));
            chk($sformatf("tbl%0d_br", i), out_branch_target, tbl[i].e_br);
            chk($sformatf("tbl%0d_side", i), 32'(side_act), 32'(tbl[i].cb));
            chk($sformatf("tbl%0d_rt", i), out_rt_val, tbl[i].rt);
        end

        // Reset while the output slot is full.
        set_idle();
        rst_n = 1'b0;
        step();
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_result", out_alu_result, 32'd0);
        rst_n = 1'b1;

        // Stall for four cycles, then release with a new op accepted on the same edge.
        out_ready = 1'b0;
        drive(ALU_ADD, 1'b1, 1'b0, 32'd5, 32'd0, 32'd7, 32'h0, 5'd0, 5'd1, 6'b100000);
        in_valid = 1'b1;
        step();
        drive(ALU_SUB, 1'b0, 1'b1, 32'd20, 32'd1, 32'd0, 32'h0, 5'd4, 5'd0, 6'b000011);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_res", k), out_alu_result, 32'd12);
            chk($sformatf("stall%0d_ctl", k), 32'({out_valid, side_act, out_wb_dest}), 32'({1'b1, 6'b100000, 5'd1}));
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_res", out_alu_result, 32'd19);
        chk("release_wb", 32'(out_wb_dest), 32'd4);

        // Flush clears the slot and drops a concurrent accept.
        drive(ALU_ADD, 1'b1, 1'b0, 32'd1, 32'd0, 32'd1, 32'h0, 5'd0, 5'd1, 6'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_dropped", 32'(out_valid), 32'd0);

`ifdef EX_MC_MUL_EN
        // Multiply: in_ready low XLEN+1 cycles, side-band travels with the op.
        set_idle();
        drive(ALU_MUL, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd3, 32'd0, 32'h200, 5'd7, 5'd9, 6'b101011);
        in_valid = 1'b1;
        #1;
        chk("mul_in_ready", 32'(in_ready), 32'd1);
        step();
        set_idle();
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            cnt++;
            step();
        end
        chk("mul_busy_cycles", 32'(cnt), 32'd33);
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_res", out_alu_result, 32'hFFFFFFFD);
        chk("mul_ctl", 32'({out_zero, side_act, out_wb_dest}), 32'({1'b0, 6'b101011, 5'd7}));
        chk("mul_rt_br", out_rt_val ^ out_branch_target, 32'd3 ^ 32'h200);

        // Flush in multiply cycle 10.
        drive(ALU_MUL, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 32'h0, 5'd1, 5'd0, 6'b100000);
        in_valid = 1'b1;
        step();
        set_idle();
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mulflush_valid", 32'(out_valid), 32'd0);
        chk("mulflush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            step();
        end
        chk("mulflush_no_out", 32'(seen), 32'd0);

        // Reset mid-multiply aborts it.
        drive(ALU_MUL, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 32'h0, 5'd1, 5'd0, 6'b100000);
        in_valid = 1'b1;
        step();
        set_idle();
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            step();
        end
        chk("mulrst_no_out", 32'(seen), 32'd0);
        chk("mulrst_in_ready", 32'(in_ready), 32'd1);
`endif

        // Random traffic against the reference model, then drain.
        set_idle();
        q.delete();
        step();
        repeat (400) rnd_cycle(1'b1);
        cnt = 0;
        while ((q.size() > 0 || out_valid) && cnt < 200) begin
            cnt++;
            rnd_cycle(1'b0);
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_idle_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mc_stage.md
EX_MC_STAGE -- requirements
Module: ex_mc_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal 16..64, power of two.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both high on an edge.
REQ-006 flush  in  1  discard in-flight and registered operation.
REQ-007 in_reg_dst, in_reg_write, in_alu_src, in_mem_write, in_mem_read, in_mem_to_reg  in  1 each  control bits.
REQ-008 in_load_mode  in  2  memory load mode, passed through; in_alu_ctrl  in  4  ALU function (package encoding).
REQ-009 in_rd, in_rt  in  REG_AW  candidate write-back destinations.
REQ-010 in_imm, in_rs_val, in_rt_val, in_pc_next  in  XLEN  sign-extended immediate, operands, PC+4.
REQ-011 out_valid / out_ready  out / in  1 / 1  downstream handshake to MEM stage.
REQ-012 out_zero, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg  out  1 each.
REQ-013 out_load_mode  out  2; out_wb_dest  out  REG_AW.
REQ-014 out_alu_result, out_rt_val, out_branch_target  out  XLEN.

Function
REQ-015 Operand B SHALL be in_imm when in_alu_src=1, else in_rt_val.
REQ-016 ALU ops SHALL be ADD, SUB, AND, OR, NOR, SLT (signed, result 1/0), SLL, SRL, MUL; results truncated to XLEN; undefined codes yield 0.
REQ-017 Shift amount SHALL be in_imm[6+log2(XLEN)-1:6], applied to operand B.
REQ-018 out_wb_dest SHALL be in_rd when in_reg_dst=1, else in_rt.
REQ-019 out_branch_target SHALL be in_pc_next + (in_imm << 2), modulo 2^XLEN.
REQ-020 out_zero SHALL be 1 exactly when out_alu_result == 0.
REQ-021 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-022 Non-MUL op accepted at edge N SHALL appear registered with out_valid=1 after edge N (latency 1).
REQ-023 Registered outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 FSM states IDLE, MUL, DONE: IDLE->MUL on accepted MUL; MUL counts XLEN cycles then ->DONE; DONE loads output register and ->IDLE when output slot free (!out_valid || out_ready).
REQ-025 MUL SHALL be radix-2 shift-add, low XLEN bits of product; accept-to-out_valid latency XLEN+1 cycles with slot free.
REQ-026 Simultaneous out_ready handshake and new accept SHALL replace output contents in the same edge without bubble.
REQ-027 flush SHALL clear out_valid and return FSM to IDLE on the next edge; flush overrides a concurrent accept (operation dropped).
REQ-028 Control bits and out_rt_val SHALL be captured at accept and carried with their own operation, including across MUL.

Reset
REQ-029 rst_n=0 at an edge SHALL set FSM IDLE, counter 0, out_valid 0, all output registers 0; in_ready SHALL be 0 while rst_n=0.
REQ-030 Reset mid-MUL SHALL abort the multiply with no output produced.

Configuration
REQ-031 Macro EX_MC_MUL_EN defined: MUL supported per REQ-024/025.
REQ-032 EX_MC_MUL_EN undefined: no MUL FSM states or counter; MUL code treated as undefined (result 0, latency 1); in_ready = !out_valid || out_ready.

Structure
REQ-033 Package ex_mc_pkg SHALL hold ALU control encodings and FSM state typedef.
REQ-034 Sub-module ex_mc_mul SHALL implement the iterative multiplier (start, busy, done, product).

Verification
REQ-035 ADD rs=5, imm=7, alu_src=1, out_ready=1 -> next cycle out_valid=1, result 12, zero=0.
REQ-036 SUB rs=9, rt=9, reg_dst=1, rd=3 -> result 0, zero=1, wb_dest=3.
REQ-037 MUL 0xFFFF_FFFF x 3 (XLEN=32) -> in_ready low 33 cycles, result 0xFFFF_FFFD.
REQ-038 out_ready=0 for 4 cycles after an ADD -> outputs stable, in_ready=0; release -> next op accepted same edge.
REQ-039 flush asserted during MUL cycle 10 -> out_valid stays 0, in_ready high next cycle.
REQ-040 pc_next=0x100, imm=0xFFFF_FFFF -> branch_target 0xFC; SLL rt=1, shamt 31 -> 0x8000_0000.
